// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter and sequencer for a shared 8:1 mux.
// It grants one requester at a time, drives the mux select with that
// requester's index, and holds the grant until the owner releases it.
// Every grant is followed by a one-cycle bubble so the mux output can settle.
// All outputs come straight from flops.
// Optional feature: define ARB_TIMEOUT_EN to force a release after HOLD_MAX
// cycles of continuous grant. When it is set, timeout pulses for that cycle.
module mux_rr_arbiter #(
  parameter int N_REQ    = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [2:0]       sel,
  output logic             sel_valid,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [2:0]       sel_q, sel_d;
  logic             sel_valid_q, sel_valid_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] scan_idx;
  logic       rel_normal;
  logic       hold_hit;
  logic       grant_start;
  logic       rel_forced;

  // Rotating priority search: first set request at or above ptr, wrapping 7 -> 0.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    win_found = 1'b0;
    win_idx   = 3'd0;
    scan_idx  = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = ptr_q + 3'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // The owner gives up the mux when it signals done or drops its own request.
  assign rel_normal = done || !req[sel_q];

  // FSM next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    grant_start = 1'b0;
    rel_forced  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d     = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          sel_d       = win_idx;
          sel_valid_d = 1'b1;
          grant_start = 1'b1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (rel_normal || hold_hit) begin
          grant_d     = '0;
          sel_valid_d = 1'b0;
          ptr_d       = sel_q + 3'd1;
          // A normal release on the same edge wins, so no timeout is flagged.
          rel_forced  = !rel_normal;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        grant_d     = '0;
        sel_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the grant without waiting for an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      grant_q     <= '0;
      sel_q       <= 3'd0;
      sel_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  // The counter reaches HOLD_MAX on the edge that ends the HOLD_MAX-th granted cycle.
  assign hold_hit = (state_q == GRANT) && (hold_q + 8'd1 == 8'(HOLD_MAX));

  // Hold counter clears on grant entry and advances for each cycle the grant is held.
  always_comb begin
    hold_d    = hold_q;
    timeout_d = rel_forced;
    if (grant_start) begin
      hold_d = 8'd0;
    end else if (state_q == GRANT && state_d == GRANT) begin
      hold_d = hold_q + 8'd1;
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign hold_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter.
// It honours ARB_TIMEOUT_EN in the same way as the design.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       sel_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  mux_rr_arbiter #(.N_REQ(8), .HOLD_MAX(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .sel       (sel),
    .sel_valid (sel_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp_grant, input logic [2:0] exp_sel,
                           input logic exp_valid);
    check({tag, ".grant"}, grant, exp_grant);
    check({tag, ".sel"}, 8'(sel), 8'(exp_sel));
    check({tag, ".sel_valid"}, 8'(sel_valid), 8'(exp_valid));
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    done  = 1'b0;

    // Reset state
    #3;
    check_out("reset", 8'h00, 3'd0, 1'b0);
    check("reset.timeout", 8'(timeout), 8'h00);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_out("idle_no_req", 8'h00, 3'd0, 1'b0);

    // Single request
    req = 8'h20;
    tick();
    check_out("single.grant", 8'h20, 3'd5, 1'b1);
    done = 1'b1;
    tick();
    check_out("single.release", 8'h00, 3'd5, 1'b0);
    done = 1'b0;
    req  = 8'h00;
    tick();
    check_out("single.bubble", 8'h00, 3'd5, 1'b0);
    // ptr is now 6, so owner 6 must win over owner 0
    req = 8'h41;
    tick();
    check_out("ptr6.grant", 8'h40, 3'd6, 1'b1);

    // Wrap and fairness: ptr 7 after owner 6 releases
    done = 1'b1;
    req  = 8'h81;
    tick();
    check_out("wrap.rel6", 8'h00, 3'd6, 1'b0);
    done = 1'b0;
    tick();
    check("wrap.bubble6", grant, 8'h00);
    tick();
    check_out("wrap.grant7", 8'h80, 3'd7, 1'b1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("wrap.rel7", grant, 8'h00);
    tick();
    check("wrap.bubble7", grant, 8'h00);
    tick();
    check_out("wrap.grant0", 8'h01, 3'd0, 1'b1);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    tick();

    // Full rotation from ptr 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req   = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] exp_g;
      exp_g = 8'h01 << (k % 8);
      tick();
      check_out($sformatf("rot%0d.grant", k), exp_g, 3'(k % 8), 1'b1);
      done = 1'b1;
      tick();
      check($sformatf("rot%0d.release", k), grant, 8'h00);
      done = 1'b0;
      tick();
      check($sformatf("rot%0d.bubble", k), grant, 8'h00);
    end
    req = 8'h00;
    tick();

    // Drop without done; ptr is 1 so owner 3 wins, then pending owner 1 follows
    req = 8'h08;
    tick();
    check_out("drop.grant3", 8'h08, 3'd3, 1'b1);
    req = 8'h02;
    tick();
    check_out("drop.release", 8'h00, 3'd3, 1'b0);
    tick();
    check("drop.bubble", grant, 8'h00);
    tick();
    check_out("drop.grant1", 8'h02, 3'd1, 1'b1);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    tick();

    // Reset mid-grant
    req = 8'h10;
    tick();
    check_out("rstmid.grant", 8'h10, 3'd4, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_out("rstmid.async", 8'h00, 3'd0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check_out("rstmid.regrant", 8'h10, 3'd4, 1'b1);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    tick();
    check("pre_timeout.idle", grant, 8'h00);

    // Long hold on owner 2
    req = 8'h04;
    tick();
    check_out("hold.grant", 8'h04, 3'd2, 1'b1);
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c < 16; c++) begin
      tick();
      check($sformatf("hold%0d.grant", c), grant, 8'h04);
      check($sformatf("hold%0d.timeout", c), 8'(timeout), 8'h00);
    end
    tick();
    check_out("timeout.release", 8'h00, 3'd2, 1'b0);
    check("timeout.pulse", 8'(timeout), 8'h01);
    tick();
    check("timeout.bubble", grant, 8'h00);
    check("timeout.pulse_end", 8'(timeout), 8'h00);
    tick();
    check_out("timeout.regrant", 8'h04, 3'd2, 1'b1);
`else
    for (int c = 1; c < 30; c++) begin
      tick();
      check($sformatf("hold%0d.grant", c), grant, 8'h04);
      check($sformatf("hold%0d.timeout", c), 8'(timeout), 8'h00);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
